// File: rtl/downstream_pkg.sv
// Shared types, default widths and the saturating adder for the downstream
// cancelled-order accumulator.
package downstream_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RD   = 2'd2,
    WB   = 2'd3
  } state_e;

  localparam int unsigned DEF_NUM_CLIENTS = 32;
  localparam int unsigned DEF_CLIENT_W    = 5;
  localparam int unsigned DEF_AMT_W       = 16;
  localparam int unsigned DEF_ACC_W       = 16;

  // Result bit 64 is the clamp flag; bits [w-1:0] hold the clamped sum (w < 64).
  function automatic logic [64:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) begin
      sat_add = {1'b1, lim[63:0]};
    end else begin
      sat_add = {1'b0, sum[63:0]};
    end
  endfunction

endpackage

// File: rtl/downstream_ram_dp.sv
// Per-client total table: one write port, one read port for the update FSM and
// one read-only query port, both reads registered (read-before-write).
module downstream_ram_dp #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic [ADDR_W-1:0] qaddr_i,
  output logic [DATA_W-1:0] qdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] qdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Addresses past the table (non power-of-two depth) read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      qdata_q <= '0;
    end else begin
      rdata_q <= (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;
      qdata_q <= (32'(qaddr_i) < DEPTH) ? mem_q[qaddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;
  assign qdata_o = qdata_q;

endmodule

// File: rtl/downstream_cxl_accum.sv
// Per-client saturating accumulator: table sweep after reset, then one
// read-modify-write per accepted request (IDLE -> RD -> WB), with optional dedup.
module downstream_cxl_accum
  import downstream_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int unsigned CLIENT_W    = DEF_CLIENT_W,
  parameter int unsigned AMT_W       = DEF_AMT_W,
  parameter int unsigned ACC_W       = DEF_ACC_W,
  parameter bit          DEDUP       = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CLIENT_W-1:0] in_client,
  input  logic [AMT_W-1:0]    in_amount,
  input  logic                in_clear,
  input  logic [CLIENT_W-1:0] q_client,
  output logic [ACC_W-1:0]    q_data,
  output logic                upd_valid,
  output logic [CLIENT_W-1:0] upd_client,
  output logic [ACC_W-1:0]    upd_total,
  output logic                upd_sat,
  output logic                upd_dropped,
  output logic                init_done
);

  localparam logic [CLIENT_W-1:0] LAST_IDX = CLIENT_W'(NUM_CLIENTS - 1);

  state_e state_q, state_d;
  logic [CLIENT_W-1:0] cnt_q, cnt_d;
  logic                init_done_q, init_done_d;
  logic [CLIENT_W-1:0] cli_q, cli_d;
  logic [AMT_W-1:0]    amt_q, amt_d;
  logic                clr_q, clr_d;
  logic                prev_valid_q, prev_valid_d;
  logic [CLIENT_W-1:0] prev_cli_q, prev_cli_d;
  logic [AMT_W-1:0]    prev_amt_q, prev_amt_d;
  logic                upd_valid_q, upd_valid_d;
  logic [CLIENT_W-1:0] upd_client_q, upd_client_d;
  logic [ACC_W-1:0]    upd_total_q, upd_total_d;
  logic                upd_sat_q, upd_sat_d;
  logic                upd_dropped_q, upd_dropped_d;

  logic                ram_we;
  logic [CLIENT_W-1:0] ram_waddr;
  logic [ACC_W-1:0]    ram_wdata;
  logic [ACC_W-1:0]    rd_data;

  logic [64:0]         sat_res;
  logic [ACC_W-1:0]    sum_val;
  logic                sum_sat;
  logic [63-ACC_W:0]   sat_hi_unused;
  logic                in_range;
  logic                is_dup;

  downstream_ram_dp #(
    .DEPTH  (NUM_CLIENTS),
    .ADDR_W (CLIENT_W),
    .DATA_W (ACC_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (cli_q),
    .rdata_o (rd_data),
    .qaddr_i (q_client),
    .qdata_o (q_data)
  );

  assign sat_res       = sat_add(64'(rd_data), 64'(amt_q), ACC_W);
  assign sum_val       = sat_res[ACC_W-1:0];
  assign sum_sat       = sat_res[64];
  assign sat_hi_unused = sat_res[63:ACC_W];
  assign in_range      = 32'(cli_q) < NUM_CLIENTS;
  assign is_dup        = DEDUP && prev_valid_q && !clr_q &&
                         (prev_cli_q == cli_q) && (prev_amt_q == amt_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    init_done_d   = init_done_q;
    cli_d         = cli_q;
    amt_d         = amt_q;
    clr_d         = clr_q;
    prev_valid_d  = prev_valid_q;
    prev_cli_d    = prev_cli_q;
    prev_amt_d    = prev_amt_q;
    upd_valid_d   = 1'b0;
    upd_client_d  = upd_client_q;
    upd_total_d   = upd_total_q;
    upd_sat_d     = upd_sat_q;
    upd_dropped_d = upd_dropped_q;
    ram_we        = 1'b0;
    ram_waddr     = cli_q;
    ram_wdata     = '0;

    case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        cnt_d     = cnt_q + CLIENT_W'(1);
        if (cnt_q == LAST_IDX) begin
          cnt_d       = '0;
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      IDLE: begin
        if (in_valid) begin
          cli_d   = in_client;
          amt_d   = in_amount;
          clr_d   = in_clear;
          state_d = RD;
        end
      end
      RD: begin
        state_d = WB;
      end
      WB: begin
        state_d       = IDLE;
        upd_valid_d   = 1'b1;
        upd_client_d  = cli_q;
        upd_sat_d     = 1'b0;
        upd_dropped_d = 1'b0;
        if (!in_range) begin
          upd_total_d   = '0;
          upd_dropped_d = 1'b1;
        end else if (clr_q) begin
          ram_we       = 1'b1;
          upd_total_d  = '0;
          prev_valid_d = 1'b0;
        end else if (is_dup) begin
          upd_total_d   = rd_data;
          upd_dropped_d = 1'b1;
        end else begin
          ram_we      = 1'b1;
          ram_wdata   = sum_val;
          upd_total_d = sum_val;
          upd_sat_d   = sum_sat;
          if (DEDUP) begin
            prev_valid_d = 1'b1;
            prev_cli_d   = cli_q;
            prev_amt_d   = amt_q;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      init_done_q   <= 1'b0;
      cli_q         <= '0;
      amt_q         <= '0;
      clr_q         <= 1'b0;
      prev_valid_q  <= 1'b0;
      prev_cli_q    <= '0;
      prev_amt_q    <= '0;
      upd_valid_q   <= 1'b0;
      upd_client_q  <= '0;
      upd_total_q   <= '0;
      upd_sat_q     <= 1'b0;
      upd_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_done_q   <= init_done_d;
      cli_q         <= cli_d;
      amt_q         <= amt_d;
      clr_q         <= clr_d;
      prev_valid_q  <= prev_valid_d;
      prev_cli_q    <= prev_cli_d;
      prev_amt_q    <= prev_amt_d;
      upd_valid_q   <= upd_valid_d;
      upd_client_q  <= upd_client_d;
      upd_total_q   <= upd_total_d;
      upd_sat_q     <= upd_sat_d;
      upd_dropped_q <= upd_dropped_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign init_done   = init_done_q;
  assign upd_valid   = upd_valid_q;
  assign upd_client  = upd_client_q;
  assign upd_total   = upd_total_q;
  assign upd_sat     = upd_sat_q;
  assign upd_dropped = upd_dropped_q;

endmodule
